pcap_dma_packer: RTL and testbench

// - Sits directly downstream of pcap_core. Buffers its 32-bit capture stream (pcap_dat/pcap_dat_valid) in an on-chip FIFO.
// - Slices the buffered data into DMA blocks of BLOCK_SIZE words and streams each block to the DMA engine behind a req/ack handshake.
// - Drives dma_full back to pcap_core for backpressure.
// - On pcap_done, flushes the partial tail block and flags it as last.

---
 rtl/pcap_pkg.sv | 20 ++
 rtl/pcap_sync_fifo.sv | 71 +++++++
 rtl/pcap_dma_packer.sv | 184 ++++++++++++++++++
 tb/tb_pcap_dma_packer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcap_pkg.sv
// ---------------------------------------------------------------------------
// pcap_pkg
// Shared constants for the pcap DMA packer: FSM state encoding, default
// FIFO depth/headroom and bus widths.
// ---------------------------------------------------------------------------
package pcap_pkg;

    localparam int unsigned PCAP_AW_DEF       = 10;
    localparam int unsigned PCAP_HEADROOM_DEF = 16;
    localparam int unsigned PCAP_DAT_W        = 32;
    localparam int unsigned PCAP_LEN_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } pcap_state_t;

endpackage

// File: rtl/pcap_sync_fifo.sv
// ---------------------------------------------------------------------------
// pcap_sync_fifo
// Single-clock first-word-fall-through FIFO with occupancy output.
// Ports:
//   clk_i, reset_i   clock, async active-high reset
//   clr_i            synchronous clear (pointers to zero)
//   wr_en_i/wr_dat_i write strobe and data; ignored while full
//   rd_en_i          pop; ignored while empty
//   rd_dat_o         head-of-queue word (valid whenever !empty_o)
//   empty_o, full_o  status
//   level_o          occupancy, 0..2**AW
// ---------------------------------------------------------------------------
module pcap_sync_fifo
    import pcap_pkg::*;
#(
    parameter int unsigned AW = PCAP_AW_DEF,
    parameter int unsigned DW = PCAP_DAT_W
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_dat_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_wr    = wr_en_i & ~w_full;
    assign w_rd    = rd_en_i & ~w_empty;

    // Pointer update; clear wins over any concurrent push/pop
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (w_wr && !clr_i) r_mem[r_wptr[AW-1:0]] <= wr_dat_i;
    end

    assign rd_dat_o = r_mem[r_rptr[AW-1:0]];
    assign empty_o  = w_empty;
    assign full_o   = w_full;
    assign level_o  = r_wptr - r_rptr;

endmodule

// File: rtl/pcap_dma_packer.sv
// ---------------------------------------------------------------------------
// pcap_dma_packer
// Buffers the pcap_core capture stream, slices it into DMA blocks of
// BLOCK_SIZE words behind a req/ack handshake, and flushes the partial tail
// block (flagged last) after pcap_done_i.
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   fifo_reset_i                   sync clear: empties FIFO, clears flags, FSM->IDLE
//   BLOCK_SIZE                     words per block (0 or >DEPTH means DEPTH)
//   pcap_dat_i, pcap_dat_valid_i   capture write port
//   pcap_done_i                    end-of-capture, requests a flush
//   dma_full_o                     backpressure (level >= DEPTH-HEADROOM)
//   dma_req_o/ack_i/len_o/last_o   block request handshake
//   dma_dat_o/valid_o/ready_i      block data stream
//   done_o                         one-cycle pulse when the flush has drained
//   overflow_o                     sticky dropped-word flag
//   level_o                        FIFO occupancy
// ---------------------------------------------------------------------------
module pcap_dma_packer
    import pcap_pkg::*;
#(
    parameter int unsigned AW       = PCAP_AW_DEF,
    parameter int unsigned HEADROOM = PCAP_HEADROOM_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  fifo_reset_i,
    input  logic [PCAP_LEN_W-1:0] BLOCK_SIZE,
    input  logic [PCAP_DAT_W-1:0] pcap_dat_i,
    input  logic                  pcap_dat_valid_i,
    input  logic                  pcap_done_i,
    output logic                  dma_full_o,
    output logic                  dma_req_o,
    input  logic                  dma_ack_i,
    output logic [PCAP_LEN_W-1:0] dma_len_o,
    output logic                  dma_last_o,
    output logic [PCAP_DAT_W-1:0] dma_dat_o,
    output logic                  dma_valid_o,
    input  logic                  dma_ready_i,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic [AW:0]           level_o
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam int unsigned LW       = AW + 1;
    localparam int unsigned FULL_THR = DEPTH - HEADROOM;

    pcap_state_t           r_state;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_cnt;
    logic                  r_last;
    logic                  r_req;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_flush;
    logic                  r_ovf;
    logic                  r_full;

    logic [LW-1:0]         w_level;
    logic [LW-1:0]         w_bs;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic [PCAP_DAT_W-1:0] w_rd_dat;

    // Out-of-range block sizes fall back to a whole FIFO
    always_comb begin
        w_bs = LW'(DEPTH);
        if (BLOCK_SIZE != '0 && 32'(BLOCK_SIZE) <= DEPTH) w_bs = LW'(BLOCK_SIZE);
    end

    // r_valid is only ever high in XFER, so it alone qualifies the pop
    assign w_pop = r_valid & dma_ready_i;

    pcap_sync_fifo #(
        .AW (AW),
        .DW (PCAP_DAT_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (fifo_reset_i),
        .wr_en_i  (pcap_dat_valid_i),
        .wr_dat_i (pcap_dat_i),
        .rd_en_i  (w_pop),
        .rd_dat_o (w_rd_dat),
        .empty_o  (w_fifo_empty),
        .full_o   (w_fifo_full),
        .level_o  (w_level)
    );

    // Block FSM, flush tracking and status flags
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_flush <= 1'b0;
            r_ovf   <= 1'b0;
            r_full  <= 1'b0;
        end else if (fifo_reset_i) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_flush <= 1'b0;
            r_ovf   <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_full <= (32'(w_level) >= FULL_THR);
            if (pcap_dat_valid_i && w_fifo_full) r_ovf <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_level >= w_bs) begin
                        r_len   <= w_bs;
                        r_last  <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end else if (r_flush && !w_fifo_empty) begin
                        r_len   <= w_level;
                        r_last  <= 1'b1;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end else if (r_flush) begin
                        r_done  <= 1'b1;
                        r_flush <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_REQ: begin
                    if (dma_ack_i) begin
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_cnt   <= r_len;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Leave as the final word pops so valid never lingers past the block
                    if (w_pop) begin
                        r_cnt <= r_cnt - LW'(1);
                        if (r_cnt == LW'(1)) begin
                            r_valid <= 1'b0;
                            if (r_last) begin
                                r_done  <= 1'b1;
                                r_flush <= 1'b0;
                                r_state <= ST_DONE;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // A done pulse arriving as the previous flush completes is not lost
            if (pcap_done_i) r_flush <= 1'b1;
        end
    end

    assign dma_full_o  = r_full;
    assign dma_req_o   = r_req;
    assign dma_len_o   = PCAP_LEN_W'(r_len);
    assign dma_last_o  = r_last;
    assign dma_dat_o   = w_rd_dat;
    assign dma_valid_o = r_valid;
    assign done_o      = r_done;
    assign overflow_o  = r_ovf;
    assign level_o     = w_level;

endmodule

// File: tb/tb_pcap_dma_packer.sv
// ---------------------------------------------------------------------------
// tb_pcap_dma_packer
// Scoreboarded bench: written words and expected block requests are queued
// as stimulus is driven, and compared as the DMA side consumes them.
// ---------------------------------------------------------------------------
module tb_pcap_dma_packer;

    localparam int unsigned AW    = 4;
    localparam int unsigned HR    = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [15:0] len;
        logic        last;
    } req_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fifo_reset_i;
    logic [15:0] BLOCK_SIZE;
    logic [31:0] pcap_dat_i;
    logic        pcap_dat_valid_i;
    logic        pcap_done_i;
    logic        dma_full_o;
    logic        dma_req_o;
    logic        dma_ack_i;
    logic [15:0] dma_len_o;
    logic        dma_last_o;
    logic [31:0] dma_dat_o;
    logic        dma_valid_o;
    logic        dma_ready_i;
    logic        done_o;
    logic        overflow_o;
    logic [AW:0] level_o;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_dat_q [$];
    req_t        exp_req_q [$];
    bit          ack_en    = 1'b1;
    int          remaining = 0;
    int          done_cnt  = 0;
    int          req_cnt   = 0;

    always #5 clk_i = ~clk_i;

    pcap_dma_packer #(
        .AW       (AW),
        .HEADROOM (HR)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .fifo_reset_i     (fifo_reset_i),
        .BLOCK_SIZE       (BLOCK_SIZE),
        .pcap_dat_i       (pcap_dat_i),
        .pcap_dat_valid_i (pcap_dat_valid_i),
        .pcap_done_i      (pcap_done_i),
        .dma_full_o       (dma_full_o),
        .dma_req_o        (dma_req_o),
        .dma_ack_i        (dma_ack_i),
        .dma_len_o        (dma_len_o),
        .dma_last_o       (dma_last_o),
        .dma_dat_o        (dma_dat_o),
        .dma_valid_o      (dma_valid_o),
        .dma_ready_i      (dma_ready_i),
        .done_o           (done_o),
        .overflow_o       (overflow_o),
        .level_o          (level_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // DMA-side model: acks requests, checks block headers, data order and valid hold
    initial begin
        dma_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            dma_ack_i = 1'b0;
            if (done_o) begin
                done_cnt++;
                check("done_after_drain", 32'(exp_dat_q.size()), 0);
            end
            if (fifo_reset_i || reset_i) begin
                remaining = 0;
            end else begin
                if (remaining > 0) check("valid_held", 32'(dma_valid_o), 1);
                if (dma_valid_o && dma_ready_i) begin
                    if (exp_dat_q.size() == 0) check("data_pending", 0, 1);
                    else check("data", dma_dat_o, exp_dat_q.pop_front());
                    if (remaining > 0) remaining--;
                end
            end
            if (dma_req_o && ack_en && !fifo_reset_i && !reset_i) begin
                req_t r;
                req_cnt++;
                if (exp_req_q.size() == 0) begin
                    check("req_pending", 0, 1);
                end else begin
                    r = exp_req_q.pop_front();
                    check("req_len", 32'(dma_len_o), 32'(r.len));
                    check("req_last", 32'(dma_last_o), 32'(r.last));
                end
                remaining = int'(dma_len_o);
                dma_ack_i = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_words(input int n, input int keep);
        for (int i = 0; i < n; i++) begin
            pcap_dat_i       = $urandom;
            pcap_dat_valid_i = 1'b1;
            if (i < keep) exp_dat_q.push_back(pcap_dat_i);
            tick();
        end
        pcap_dat_valid_i = 1'b0;
    endtask

    task automatic push_req(input int len, input logic last);
        req_t r;
        r.len  = 16'(len);
        r.last = last;
        exp_req_q.push_back(r);
    endtask

    // mode 1: ready held high, mode 2: random ready each cycle
    task automatic drain(input int mode, input int budget);
        int k = 0;
        while ((exp_dat_q.size() != 0 || dma_req_o || dma_valid_o) && k < budget) begin
            dma_ready_i = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        dma_ready_i = 1'b1;
        check("drain_in_budget", 32'(k < budget), 1);
    endtask

    task automatic wait_done(input int budget, input int prev);
        int k = 0;
        while (done_cnt == prev && k < budget) begin
            tick();
            k++;
        end
        check("done_pulse", 32'(done_cnt - prev), 1);
    endtask

    task automatic pulse_done();
        pcap_done_i = 1'b1;
        tick();
        pcap_done_i = 1'b0;
    endtask

    initial begin
        int d0;
        int r0;
        int k;
        reset_i          = 1'b1;
        fifo_reset_i     = 1'b0;
        BLOCK_SIZE       = 16'd4;
        pcap_dat_i       = '0;
        pcap_dat_valid_i = 1'b0;
        pcap_done_i      = 1'b0;
        dma_ready_i      = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_req", 32'(dma_req_o), 0);
        check("rst_valid", 32'(dma_valid_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_ovf", 32'(overflow_o), 0);
        check("rst_level", 32'(level_o), 0);
        check("rst_full", 32'(dma_full_o), 0);
        check("rst_len", 32'(dma_len_o), 0);
        check("rst_last", 32'(dma_last_o), 0);
        reset_i = 1'b0;
        repeat (2) tick();

        // Two full blocks of 4
        push_req(4, 1'b0);
        push_req(4, 1'b0);
        write_words(8, 8);
        drain(1, 200);
        check("t1_level", 32'(level_o), 0);
        check("t1_reqs_used", 32'(exp_req_q.size()), 0);

        // Full block then flushed tail of 2
        push_req(4, 1'b0);
        push_req(2, 1'b1);
        write_words(6, 6);
        d0 = done_cnt;
        pulse_done();
        drain(1, 200);
        wait_done(10, d0);
        repeat (3) tick();
        check("t2_done_once", 32'(done_cnt - d0), 1);
        check("t2_level", 32'(level_o), 0);
        check("t2_reqs_used", 32'(exp_req_q.size()), 0);

        // Flush with empty FIFO: no request, prompt done
        d0 = done_cnt;
        r0 = req_cnt;
        pulse_done();
        wait_done(3, d0);
        repeat (3) tick();
        check("t6_no_req", 32'(req_cnt - r0), 0);
        check("t6_req_low", 32'(dma_req_o), 0);

        // Random ready inside blocks
        push_req(4, 1'b0);
        push_req(4, 1'b0);
        dma_ready_i = 1'b0;
        write_words(8, 8);
        drain(2, 400);
        check("t4_level", 32'(level_o), 0);
        check("t4_reqs_used", 32'(exp_req_q.size()), 0);

        // BLOCK_SIZE=0 means a whole-FIFO block
        BLOCK_SIZE = 16'd0;
        push_req(DEPTH, 1'b0);
        write_words(16, 16);
        drain(1, 200);
        repeat (3) tick();
        check("t7_level", 32'(level_o), 0);
        check("t7_full_clear", 32'(dma_full_o), 0);
        check("t7_reqs_used", 32'(exp_req_q.size()), 0);

        // Backpressure and overflow with the DMA stalled
        BLOCK_SIZE  = 16'd4;
        ack_en      = 1'b0;
        dma_ready_i = 1'b0;
        write_words(11, 11);
        repeat (2) tick();
        check("t3_full_below", 32'(dma_full_o), 0);
        check("t3_level11", 32'(level_o), 11);
        write_words(1, 1);
        repeat (2) tick();
        check("t3_full_at12", 32'(dma_full_o), 1);
        check("t3_level12", 32'(level_o), 12);
        check("t3_no_ovf", 32'(overflow_o), 0);
        write_words(5, 4);
        repeat (2) tick();
        check("t3_level16", 32'(level_o), 16);
        check("t3_ovf", 32'(overflow_o), 1);
        check("t3_full", 32'(dma_full_o), 1);
        check("t3_req_waiting", 32'(dma_req_o), 1);

        // Abort mid-block with two words still owed
        push_req(4, 1'b0);
        ack_en = 1'b1;
        k = 0;
        while (!dma_valid_o && k < 10) begin
            tick();
            k++;
        end
        check("t5_valid_rise", 32'(dma_valid_o), 1);
        dma_ready_i = 1'b1;
        repeat (2) tick();
        dma_ready_i = 1'b0;
        check("t5_level14", 32'(level_o), 14);
        check("t5_still_valid", 32'(dma_valid_o), 1);
        fifo_reset_i = 1'b1;
        tick();
        fifo_reset_i = 1'b0;
        exp_dat_q.delete();
        check("t5_valid_off", 32'(dma_valid_o), 0);
        check("t5_level0", 32'(level_o), 0);
        check("t5_ovf_clr", 32'(overflow_o), 0);
        check("t5_full_clr", 32'(dma_full_o), 0);
        check("t5_req_off", 32'(dma_req_o), 0);
        r0 = req_cnt;
        repeat (4) tick();
        check("t5_idle_no_req", 32'(req_cnt - r0), 0);
        check("t5_idle_no_valid", 32'(dma_valid_o), 0);
        check("t5_reqs_used", 32'(exp_req_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
